// File: rtl/wb_pkg.sv
// Shared Wishbone B3 definitions for the line burst master.
// Holds the cycle-type (CTI) and burst-type (BTE) codes, the burst FSM
// state encoding and a helper that maps a line length to its wrap BTE code.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_RETRY = 2'd2,
        ST_RESP  = 2'd3
    } wb_state_e;

    // Wrap burst type matching a line of the given number of beats.
    function automatic logic [1:0] bte_for_words(input int unsigned words);
        case (words)
            4:       return BTE_WRAP4;
            8:       return BTE_WRAP8;
            16:      return BTE_WRAP16;
            default: return BTE_LINEAR;
        endcase
    endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Beat address generator for one cache-line burst.
// Holds the line base, the start word, the current word index, the beat
// count and a registered last-beat flag.
//   load_i    : capture a new request address (adr_i) and start at its word
//   advance_i : one beat acknowledged, move to the next word of the line
//   restart_i : begin the burst again from the start word (after a retry)
//   adr_o     : current beat byte address
//   cti_o     : INCR for all beats but the last, EOB on the last
//   word_idx_o: index of the line word addressed by the current beat
//   last_o    : current beat is the final beat of the line
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LINE_WORDS = 8,
    parameter int WRAP       = 0
) (
    input  logic                          wb_clk_i,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [AW-1:0]                 adr_i,
    input  logic                          advance_i,
    input  logic                          restart_i,
    output logic [AW-1:0]                 adr_o,
    output logic [2:0]                    cti_o,
    output logic [$clog2(LINE_WORDS)-1:0] word_idx_o,
    output logic                          last_o
);

    localparam int WI = $clog2(LINE_WORDS);
    localparam int BO = $clog2(DW/8);
    localparam int LO = WI + BO;

    logic [AW-1:0] base_q,  base_d;
    logic [WI-1:0] start_q, start_d;
    logic [WI-1:0] idx_q,   idx_d;
    logic [WI-1:0] beat_q,  beat_d;
    logic          last_q,  last_d;

    // Byte-offset bits never reach the bus; the word field is unused when
    // bursts always start at the line base.
    logic unused_adr_bits;
    assign unused_adr_bits = ^adr_i[LO-1:0];

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            base_q  <= '0;
            start_q <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            base_q  <= base_d;
            start_q <= start_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        base_d  = base_q;
        start_d = start_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        last_d  = last_q;
        if (load_i) begin
            base_d  = {adr_i[AW-1:LO], {LO{1'b0}}};
            start_d = (WRAP != 0) ? adr_i[LO-1:BO] : '0;
            idx_d   = (WRAP != 0) ? adr_i[LO-1:BO] : '0;
            beat_d  = '0;
            last_d  = 1'b0;
        end else if (restart_i) begin
            idx_d   = start_q;
            beat_d  = '0;
            last_d  = 1'b0;
        end else if (advance_i) begin
            // LINE_WORDS is a power of two, so natural overflow of the
            // index keeps it inside the line in both linear and wrap modes.
            idx_d   = idx_q + 1'b1;
            beat_d  = beat_q + 1'b1;
            last_d  = (beat_q == WI'(LINE_WORDS - 2));
        end
    end

    assign adr_o      = base_q | (AW'(idx_q) << BO);
    assign cti_o      = last_q ? CTI_EOB : CTI_INCR;
    assign word_idx_o = idx_q;
    assign last_o     = last_q;

endmodule

// File: rtl/wb_line_burst_master.sv
// Wishbone B3 registered-feedback burst master that moves one cache line
// per request, for refill (read) or writeback (write), with err/rty handling.
// Ports:
//   wb_clk_i, rst               : clock, synchronous active-high reset
//   req_valid/req_ready         : line request handshake
//   req_we, req_adr, req_wdata  : request kind, requested word address, line
//   rsp_valid, rsp_err          : one-cycle completion pulse and its status
//   rsp_rdata                   : refill line, word-indexed
//   wb_*_o / wb_*_i             : Wishbone master interface
//   dbg_state_o                 : current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so nothing is
// accepted while a burst or its response is in flight. rsp_valid is a
// single-cycle pulse with no back-pressure; rsp_err and rsp_rdata are valid
// in that cycle and held until the next accept.
module wb_line_burst_master
    import wb_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int LINE_WORDS = 8,
    parameter int WRAP       = 0,
    parameter int MAX_RETRY  = 3
) (
    input  logic                     wb_clk_i,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [AW-1:0]            req_adr,
    input  logic [LINE_WORDS*DW-1:0] req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_err,
    output logic [LINE_WORDS*DW-1:0] rsp_rdata,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [AW-1:0]            wb_adr_o,
    output logic [DW/8-1:0]          wb_sel_o,
    output logic [DW-1:0]            wb_dat_o,
    output logic [2:0]               wb_cti_o,
    output logic [1:0]               wb_bte_o,
    input  logic [DW-1:0]            wb_dat_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    input  logic                     wb_rty_i,
    output wb_state_e                dbg_state_o
);

    localparam int WI = $clog2(LINE_WORDS);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [1:0] BTE_CODE = (WRAP != 0) ? bte_for_words(LINE_WORDS) : BTE_LINEAR;

    wb_state_e               state_q, state_d;
    logic                    we_q, we_d;
    logic [LINE_WORDS*DW-1:0] wdata_q, wdata_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [LINE_WORDS*DW-1:0] rdata_q;

    logic          load, advance, restart, capture;
    logic [2:0]    gen_cti;
    logic [WI-1:0] word_idx;
    logic          last_beat;
    logic          in_burst;

    wb_burst_addr_gen #(
        .AW         (AW),
        .DW         (DW),
        .LINE_WORDS (LINE_WORDS),
        .WRAP       (WRAP)
    ) u_addr_gen (
        .wb_clk_i   (wb_clk_i),
        .rst        (rst),
        .load_i     (load),
        .adr_i      (req_adr),
        .advance_i  (advance),
        .restart_i  (restart),
        .adr_o      (wb_adr_o),
        .cti_o      (gen_cti),
        .word_idx_o (word_idx),
        .last_o     (last_beat)
    );

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            retry_q   <= '0;
            rsp_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            retry_q   <= retry_d;
            rsp_err_q <= rsp_err_d;
            if (capture) begin
                rdata_q[int'(word_idx)*DW +: DW] <= wb_dat_i;
            end
        end
    end

    // Terminations are only looked at while stb is high (BURST), with
    // priority err > rty > ack.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        retry_d   = retry_q;
        rsp_err_d = rsp_err_q;
        load      = 1'b0;
        advance   = 1'b0;
        restart   = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    wdata_d   = req_wdata;
                    retry_d   = '0;
                    rsp_err_d = 1'b0;
                    load      = 1'b1;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wb_err_i) begin
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (wb_rty_i) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_RETRY;
                    end else begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end else if (wb_ack_i) begin
                    advance = 1'b1;
                    capture = !we_q;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RETRY: begin
                // One idle cycle with cyc low, then the whole line again.
                restart = 1'b1;
                state_d = ST_BURST;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_burst = (state_q == ST_BURST);

    always_comb begin
        wb_dat_o = '0;
        if (in_burst && we_q) begin
            wb_dat_o = wdata_q[int'(word_idx)*DW +: DW];
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rdata_q;
    assign wb_cyc_o    = in_burst;
    assign wb_stb_o    = in_burst;
    assign wb_we_o     = in_burst && we_q;
    assign wb_sel_o    = '1;
    assign wb_cti_o    = in_burst ? gen_cti : CTI_EOB;
    assign wb_bte_o    = in_burst ? BTE_CODE : BTE_LINEAR;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_line_burst_master.sv
// Bench for wb_line_burst_master: one linear 8-word instance and one wrap
// 4-word instance share the request and slave inputs; sel picks which one
// receives req_valid and whose outputs are checked. The idle instance has
// stb low and therefore ignores the shared terminations.
module tb_wb_line_burst_master;
    import wb_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sel = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_we = 1'b0;
    logic [31:0]  req_adr = '0;
    logic [255:0] req_wdata = '0;
    logic [31:0]  wb_dat_i = '0;
    logic         wb_ack = 1'b0;
    logic         wb_err = 1'b0;
    logic         wb_rty = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_line [16];

    logic         o0_ready, o0_valid, o0_err, o0_cyc, o0_stb, o0_we;
    logic [255:0] o0_rdata;
    logic [31:0]  o0_adr, o0_dat;
    logic [3:0]   o0_sel;
    logic [2:0]   o0_cti;
    logic [1:0]   o0_bte;
    wb_state_e    o0_state;

    logic         o1_ready, o1_valid, o1_err, o1_cyc, o1_stb, o1_we;
    logic [127:0] o1_rdata;
    logic [31:0]  o1_adr, o1_dat;
    logic [3:0]   o1_sel;
    logic [2:0]   o1_cti;
    logic [1:0]   o1_bte;
    wb_state_e    o1_state;

    always #5 clk = ~clk;

    wb_line_burst_master #(.DW(32), .AW(32), .LINE_WORDS(8), .WRAP(0), .MAX_RETRY(3)) u_dut0 (
        .wb_clk_i(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(o0_ready), .req_we(req_we),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(o0_valid), .rsp_err(o0_err), .rsp_rdata(o0_rdata),
        .wb_cyc_o(o0_cyc), .wb_stb_o(o0_stb), .wb_we_o(o0_we), .wb_adr_o(o0_adr),
        .wb_sel_o(o0_sel), .wb_dat_o(o0_dat), .wb_cti_o(o0_cti), .wb_bte_o(o0_bte),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty),
        .dbg_state_o(o0_state)
    );

    wb_line_burst_master #(.DW(32), .AW(32), .LINE_WORDS(4), .WRAP(1), .MAX_RETRY(3)) u_dut1 (
        .wb_clk_i(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(o1_ready), .req_we(req_we),
        .req_adr(req_adr), .req_wdata(req_wdata[127:0]),
        .rsp_valid(o1_valid), .rsp_err(o1_err), .rsp_rdata(o1_rdata),
        .wb_cyc_o(o1_cyc), .wb_stb_o(o1_stb), .wb_we_o(o1_we), .wb_adr_o(o1_adr),
        .wb_sel_o(o1_sel), .wb_dat_o(o1_dat), .wb_cti_o(o1_cti), .wb_bte_o(o1_bte),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty),
        .dbg_state_o(o1_state)
    );

    logic         m_ready, m_valid, m_err, m_cyc, m_stb, m_we;
    logic [255:0] m_rdata;
    logic [31:0]  m_adr, m_dat;
    logic [3:0]   m_sel;
    logic [2:0]   m_cti;
    logic [1:0]   m_bte;

    assign m_ready = sel ? o1_ready : o0_ready;
    assign m_valid = sel ? o1_valid : o0_valid;
    assign m_err   = sel ? o1_err   : o0_err;
    assign m_cyc   = sel ? o1_cyc   : o0_cyc;
    assign m_stb   = sel ? o1_stb   : o0_stb;
    assign m_we    = sel ? o1_we    : o0_we;
    assign m_rdata = sel ? {128'b0, o1_rdata} : o0_rdata;
    assign m_adr   = sel ? o1_adr   : o0_adr;
    assign m_dat   = sel ? o1_dat   : o0_dat;
    assign m_sel   = sel ? o1_sel   : o0_sel;
    assign m_cti   = sel ? o1_cti   : o0_cti;
    assign m_bte   = sel ? o1_bte   : o0_bte;

    // Runs one line transfer on the selected instance and checks every bus
    // cycle against the line transfer rules. The slave script: each beat waits
    // a random number of cycles in [wlo,whi]; the first rty_count attempts
    // are terminated by rty at beat rty_beat; attempt 0 is terminated by
    // err+ack at beat err_beat (-1 = never). Latency counts cycles from the
    // accept cycle (cycle 0) to the response cycle.
    task automatic drive_line(input logic we, input logic [31:0] adr, input logic [255:0] wdata,
                              input int wlo, input int whi, input int rty_count, input int rty_beat,
                              input int err_beat, input bit dpat, output int latency);
        int n, start, idx, attempt, w;
        logic [31:0] base, exp_adr;
        logic [2:0]  exp_cti;
        logic [1:0]  exp_bte;
        logic [43:0] got_v, exp_v;
        logic [7:0]  got_r, exp_r;
        bit done, restart, exp_err;
        n       = sel ? 4 : 8;
        start   = sel ? int'((adr >> 2) % 32'(n)) : 0;
        base    = adr & ~(32'(n * 4) - 32'd1);
        exp_bte = sel ? 2'b01 : 2'b00;

        @(negedge clk);
        checks++;
        if (m_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_idle: got %b expected 1", m_ready);
        end
        req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        latency = 1;

        attempt = 0; done = 1'b0; exp_err = 1'b0;
        while (!done) begin
            restart = 1'b0;
            for (int k = 0; k < n && !done && !restart; k++) begin
                idx     = (start + k) % n;
                exp_adr = base | 32'(idx * 4);
                exp_cti = (k == n - 1) ? 3'b111 : 3'b010;
                w       = $urandom_range(whi, wlo);
                for (int j = 0; j <= w; j++) begin
                    exp_v = {1'b1, 1'b1, we, exp_adr, exp_cti, exp_bte, 4'hF};
                    got_v = {m_cyc, m_stb, m_we, m_adr, m_cti, m_bte, m_sel};
                    checks++;
                    if (got_v !== exp_v) begin
                        failures++;
                        $display("FAIL beat_ctrl k=%0d att=%0d: got %h expected %h", k, attempt, got_v, exp_v);
                    end
                    if (we) begin
                        checks++;
                        if (m_dat !== wdata[idx*32 +: 32]) begin
                            failures++;
                            $display("FAIL beat_wdata k=%0d: got %h expected %h", k, m_dat, wdata[idx*32 +: 32]);
                        end
                    end
                    if (j == w) begin
                        if (attempt == 0 && k == err_beat) begin
                            wb_err = 1'b1; wb_ack = 1'b1; wb_dat_i = $urandom;
                            done = 1'b1; exp_err = 1'b1;
                        end else if (attempt < rty_count && k == rty_beat) begin
                            wb_rty = 1'b1;
                            if (attempt < 3) restart = 1'b1;
                            else begin done = 1'b1; exp_err = 1'b1; end
                        end else begin
                            wb_ack = 1'b1;
                            wb_dat_i = dpat ? 32'hA0 + 32'(idx) : $urandom;
                            model_line[idx] = wb_dat_i;
                            if (k == n - 1) done = 1'b1;
                        end
                    end
                    @(negedge clk);
                    latency++;
                    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
                end
            end
            if (restart) begin
                checks++;
                if ({m_cyc, m_stb, m_valid} !== 3'b000) begin
                    failures++;
                    $display("FAIL retry_gap: got %b expected 000", {m_cyc, m_stb, m_valid});
                end
                wb_ack = 1'b1;  // stb is low: must be ignored
                @(negedge clk);
                latency++;
                wb_ack = 1'b0;
                attempt++;
            end
        end

        exp_r = {1'b1, exp_err, 1'b0, 1'b0, 3'b111, 1'b0};
        got_r = {m_valid, m_err, m_cyc, m_stb, m_cti, m_ready};
        checks++;
        if (got_r !== exp_r) begin
            failures++;
            $display("FAIL resp: got %b expected %b", got_r, exp_r);
        end
        if (!we && !exp_err) begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (m_rdata[i*32 +: 32] !== model_line[i]) begin
                    failures++;
                    $display("FAIL rdata[%0d]: got %h expected %h", i, m_rdata[i*32 +: 32], model_line[i]);
                end
            end
        end
        wb_ack = 1'b1;  // stray ack in the response cycle
        @(negedge clk);
        wb_ack = 1'b0;
        checks++;
        if ({m_valid, m_ready, m_cyc} !== 3'b010) begin
            failures++;
            $display("FAIL after_resp: got %b expected 010", {m_valid, m_ready, m_cyc});
        end
    endtask

    task automatic test_reset();
        logic [74:0] exp_v, got0, got1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_v = {6'b100000, 32'h0, 3'b111, 2'b00, 32'h0};
        got0  = {o0_ready, o0_valid, o0_err, o0_cyc, o0_stb, o0_we, o0_adr, o0_cti, o0_bte, o0_dat};
        got1  = {o1_ready, o1_valid, o1_err, o1_cyc, o1_stb, o1_we, o1_adr, o1_cti, o1_bte, o1_dat};
        checks++;
        if (got0 !== exp_v) begin failures++; $display("FAIL reset_dut0: got %h expected %h", got0, exp_v); end
        checks++;
        if (got1 !== exp_v) begin failures++; $display("FAIL reset_dut1: got %h expected %h", got1, exp_v); end
        checks++;
        if ({o0_rdata, o1_rdata} !== '0) begin failures++; $display("FAIL reset_rdata: got nonzero expected 0"); end
    endtask

    task automatic test_linear_read();
        int lat;
        sel = 1'b0;
        drive_line(1'b0, 32'h1000_0014, '0, 0, 0, 0, 0, -1, 1'b1, lat);
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL linear_latency: got %0d expected 9", lat); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_rdata[i*32 +: 32] !== 32'hA0 + 32'(i)) begin
                failures++;
                $display("FAIL linear_word[%0d]: got %h expected %h", i, m_rdata[i*32 +: 32], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_wrap_read();
        int lat;
        sel = 1'b1;
        drive_line(1'b0, 32'h0000_0048, '0, 0, 0, 0, 0, -1, 1'b1, lat);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL wrap_latency: got %0d expected 5", lat); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_rdata[i*32 +: 32] !== 32'hA0 + 32'(i)) begin
                failures++;
                $display("FAIL wrap_word[%0d]: got %h expected %h", i, m_rdata[i*32 +: 32], 32'hA0 + 32'(i));
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_writeback_waits();
        int lat;
        logic [255:0] wd;
        for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'h11 * 32'(i + 1);
        sel = 1'b0;
        drive_line(1'b1, 32'h2000_0040, wd, 2, 2, 0, 0, -1, 1'b0, lat);
        checks++;
        if (lat !== 25) begin failures++; $display("FAIL wb_latency: got %0d expected 25", lat); end
    endtask

    task automatic test_retry();
        int lat;
        sel = 1'b0;
        drive_line(1'b0, 32'h3000_0100, '0, 0, 0, 2, 3, -1, 1'b0, lat);
        checks++;
        if (lat !== 19) begin failures++; $display("FAIL retry_ok_latency: got %0d expected 19", lat); end
        drive_line(1'b0, 32'h3000_0200, '0, 0, 0, 4, 3, -1, 1'b0, lat);
        checks++;
        if (lat !== 20) begin failures++; $display("FAIL retry_exhaust_latency: got %0d expected 20", lat); end
    endtask

    task automatic test_err_ack();
        int lat;
        sel = 1'b0;
        drive_line(1'b0, 32'h4000_0000, '0, 0, 0, 0, 0, 5, 1'b0, lat);
        checks++;
        if (lat !== 7) begin failures++; $display("FAIL err_latency: got %0d expected 7", lat); end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        logic [39:0] got_v;
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h5000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wb_ack = 1'b1; wb_dat_i = 32'(k);
            @(negedge clk);
            wb_ack = 1'b0;
        end
        checks++;
        if (m_adr !== 32'h5000_0010) begin failures++; $display("FAIL mid_beat4_adr: got %h expected 50000010", m_adr); end
        rst = 1'b1; wb_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0; wb_ack = 1'b0;
        got_v = {m_cyc, m_stb, m_cti, m_ready, m_valid, m_adr};
        checks++;
        if (got_v !== {2'b00, 3'b111, 1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h expected %h", got_v, {2'b00, 3'b111, 1'b1, 1'b0, 32'h0});
        end
        checks++;
        if (m_rdata !== '0) begin failures++; $display("FAIL mid_reset_rdata: got nonzero expected 0"); end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_no_rsp: got %b expected 0", m_valid); end
        drive_line(1'b0, 32'h5000_0020, '0, 0, 1, 0, 0, -1, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat, rc, n;
        logic [255:0] wd;
        for (int t = 0; t < 10; t++) begin
            sel = 1'($urandom_range(1, 0));
            n = sel ? 4 : 8;
            for (int i = 0; i < 8; i++) wd[i*32 +: 32] = $urandom;
            case ($urandom_range(3, 0))
                0, 1:    rc = 0;
                2:       rc = 1;
                default: rc = 4;
            endcase
            drive_line(1'($urandom_range(1, 0)), $urandom, wd, 0, 2, rc,
                       $urandom_range(n - 1, 0),
                       ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1,
                       1'b0, lat);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_linear_read();
        test_wrap_read();
        test_writeback_waits();
        test_retry();
        test_err_ack();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_line_burst_master.md
Name: wb_line_burst_master

Overview:
- Parametrised successor to the single-purpose 8-word read-refill Wishbone BIU.
- Moves one whole cache line per request over a Wishbone B3 registered-feedback burst.
- Handles both refill (read) and writeback (write), in linear or wrap (critical-word-first) order, with err/rty handling.
- Sits between the I/D-cache line interface and the system Wishbone interconnect, in a single clock domain.

Parameters:
DW, 32, Wishbone data width in bits (32 or 64)
AW, 32, Wishbone address width
LINE_WORDS, 8, beats per line; 4, 8 or 16
WRAP, 0, 0 = linear burst from line-aligned address; 1 = wrap burst starting at requested word
MAX_RETRY, 3, rty-terminated attempts restarted before reporting error

Ports:
wb_clk_i  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  line request
req_ready  out  1  block idle; request accepted when req_valid & req_ready
req_we  in  1  1 = writeback, 0 = refill
req_adr  in  AW  byte address of requested word
req_wdata  in  LINE_WORDS*DW  writeback line; word i at bits [i*DW +: DW]
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  qualifies rsp_valid; 1 = burst failed
rsp_rdata  out  LINE_WORDS*DW  refill line, word-indexed, held until next accept
wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls
wb_adr_o  out  AW  beat address
wb_sel_o  out  DW/8  byte selects, all ones
wb_dat_o  out  DW  write data
wb_cti_o  out  3  010 incrementing, 111 end of burst
wb_bte_o  out  2  burst type
wb_dat_i  in  DW  read data
wb_ack_i, wb_err_i, wb_rty_i  in  1 each  terminations

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_err=0, cyc/stb/we=0, adr=0, cti=111, bte=00, dat_o=0, rsp_rdata=0.
- Reset asserted mid-burst: all outputs return to reset values on the next edge and no response is issued.
- States: IDLE, BURST, RETRY, RESP.
- IDLE: req_ready=1. On accept, latch we, address and wdata, clear beat and retry counters, go to BURST. cyc/stb are asserted on the cycle after accept.
- Start word:
  - WRAP=0: word index 0, address = req_adr with its low log2(LINE_WORDS*DW/8) bits zeroed; bte=00.
  - WRAP=1: word index = req_adr word field; bte = 01/10/11 for 4/8/16 words.
- Beat address = line base | (word index << log2(DW/8)).
- Word index increments mod LINE_WORDS on each ack, so it wraps inside the line in both modes.
- cti=010 on every beat except the last (beat count == LINE_WORDS-1), which uses 111.
- stb stays high for the whole burst, so a zero-wait slave acks every cycle.
- Write data: wb_dat_o = latched word[current word index], updated in the same cycle adr advances.
- Read data: on ack, wb_dat_i is written to rsp_rdata[word index].
- Termination priority, evaluated only while stb=1: err > rty > ack. Simultaneous err+ack is treated as err.
- Last-beat ack: cyc/stb/cti return to 0/0/111 on the next edge, go to RESP.
- err on any beat: drop cyc/stb next edge, go to RESP with rsp_err=1.
- rty on any beat:
  - If retry count < MAX_RETRY: increment it, go to RETRY for exactly one cycle with cyc=0, then restart the burst from the start word with beat count 0. Previously captured read words get overwritten.
  - Otherwise: go to RESP with rsp_err=1.
- RESP: rsp_valid=1 for one cycle, req_ready=0, then IDLE.
- Zero-wait read with LINE_WORDS=N: accept at cycle 0, beats at cycles 1..N, rsp_valid at cycle N+1, next accept possible at cycle N+2.
- Inputs ack/err/rty arriving while stb=0 are ignored.
- Counters: beat counter is log2(LINE_WORDS) bits plus a terminal flag; retry counter is clog2(MAX_RETRY+1) bits.

Decomposition:
- Shared package wb_pkg holds:
  - CTI constants (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111);
  - BTE constants (BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16);
  - the state enum;
  - a function mapping LINE_WORDS to a BTE code.
- One sub-module, wb_burst_addr_gen: holds line base, word index, beat count and last-beat flag; inputs load/advance/restart, outputs adr/cti/word index.

Test Plan:
- LINE_WORDS=8, WRAP=0, read of 0x1000_0014, zero-wait slave with dat=0xA0+i -> adr 0x1000_0000..0x1000_001C, cti 010 x7 then 111, rsp_valid at cycle 9, rsp_rdata word i = 0xA0+i, rsp_err=0.
- WRAP=1, LINE_WORDS=4, read of 0x0000_0048 -> bte=01, adr sequence 0x48,0x4C,0x40,0x44, rsp_rdata words land at index 2,3,0,1.
- Writeback of words 0x11..0x88 with slave inserting 2 wait states per beat -> wb_we_o=1 throughout, dat_o matches the addressed word, adr held while ack=0, single rsp_valid with err=0.
- rty on beat 3 twice, then a clean burst (MAX_RETRY=3) -> two 1-cycle cyc gaps, burst restarts at the start word, rsp_err=0; the same test with 4 rty -> rsp_err=1.
- err together with ack on beat 5 -> cyc low next cycle, no further beats, rsp_valid with rsp_err=1.
- rst asserted at beat 4 -> cyc/stb=0, cti=111, req_ready=1 next cycle, no rsp_valid; the following request completes normally.
